// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR numbers, funct3 encodings,
// register bit positions, interrupt causes and read-only identification constants.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // funct3[1:0] selects the access kind; the immediate forms share it with the register forms.
    typedef enum logic [1:0] {
        CSR_ACCESS_NONE  = 2'b00,
        CSR_ACCESS_WRITE = 2'b01,
        CSR_ACCESS_SET   = 2'b10,
        CSR_ACCESS_CLEAR = 2'b11
    } csrAccess_t;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;

    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;
    localparam logic [31:0] MIE_WRITABLE = 32'h0000_0888;

    localparam logic [31:0] CAUSE_M_SOFTWARE = 32'h8000_0003;
    localparam logic [31:0] CAUSE_M_TIMER    = 32'h8000_0007;
    localparam logic [31:0] CAUSE_M_EXTERNAL = 32'h8000_000B;

    localparam logic [31:0] MVENDORID = 32'h0000_0000;
    localparam logic [31:0] MARCHID   = 32'h0000_0000;
    localparam logic [31:0] MIMPID    = 32'h0000_0000;
    localparam logic [31:0] MISA      = 32'h4000_0100;  // RV32I

    function automatic logic [31:0] applyAccess(input csrAccess_t kind,
                                                input logic [31:0] oldValue,
                                                input logic [31:0] operand);
        case (kind)
            CSR_ACCESS_SET:   applyAccess = oldValue | operand;
            CSR_ACCESS_CLEAR: applyAccess = oldValue & ~operand;
            default:          applyAccess = operand;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running counter with independent low/high 32-bit write ports; a write wins over
// the increment in the same cycle.
module csr_counter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Increment,
    input  logic             i_WriteLow,
    input  logic             i_WriteHigh,
    input  logic [31:0]      i_WriteData,
    output logic [WIDTH-1:0] o_Value
);
    localparam int unsigned HIGH_WIDTH = WIDTH - 32;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            o_Value <= '0;
        end else if (i_WriteLow) begin
            o_Value[31:0] <= i_WriteData;
        end else if (i_WriteHigh) begin
            o_Value[WIDTH-1:32] <= i_WriteData[HIGH_WIDTH-1:0];
        end else if (i_Increment) begin
            o_Value <= o_Value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: CSR read/modify/write, trap entry and MRET sequencing of the
// mstatus enable stack, cycle/instret counters and pending-interrupt reporting.
module csr_unit
    import csr_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter logic [31:0] HART_ID       = 32'h0000_0000,
    parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000,
    parameter bit          VECTORED_EN   = 1'b1
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Valid,
    input  logic [2:0]  i_Op,
    input  logic [11:0] i_CsrNumber,
    input  logic        i_SrcZero,
    input  logic [31:0] i_InputData,
    output logic [31:0] o_ReadData,
    output logic        o_Illegal,
    input  logic        i_TrapValid,
    input  logic [31:0] i_TrapCause,
    input  logic [31:0] i_TrapPc,
    input  logic [31:0] i_TrapValue,
    input  logic        i_MretValid,
    input  logic        i_InstRetired,
    input  logic        i_IrqExternal,
    input  logic        i_IrqTimer,
    input  logic        i_IrqSoftware,
    output logic [31:0] o_TrapVector,
    output logic [31:0] o_MretPc,
    output logic        o_IrqPending,
    output logic [31:0] o_IrqCause
);
    logic                     statusMie, statusMpie;
    logic [29:0]              mtvecBase;
    logic                     mtvecMode;
    logic [31:0]              mieReg, mscratch, mcause, mtval;
    logic [29:0]              mepcHigh;
    logic [2:0]               irqSync;  // {external, timer, software}
    logic [COUNTER_WIDTH-1:0] mcycle, minstret;

    logic [31:0] mstatusView, mipView, pendingEnabled;
    logic [31:0] readValue, newValue;
    logic        implemented, writeAttempt, illegal, doWrite;
    csrAccess_t  accessKind;

    logic writeMstatus, writeMie, writeMtvec, writeMscratch, writeMepc, writeMcause, writeMtval;
    logic writeMcycle, writeMcycleh, writeMinstret, writeMinstreth;

    // NOTE: every variable gets a default at the top of an always_comb so no path can infer a latch.
    always_comb begin
        mstatusView               = MSTATUS_MPP_M;
        mstatusView[MSTATUS_MIE]  = statusMie;
        mstatusView[MSTATUS_MPIE] = statusMpie;
        mipView                   = '0;
        mipView[MIP_MEIP]         = irqSync[2];
        mipView[MIP_MTIP]         = irqSync[1];
        mipView[MIP_MSIP]         = irqSync[0];
    end

    always_comb begin
        readValue   = '0;
        implemented = 1'b1;
        case (i_CsrNumber)
            CSR_MVENDORID: readValue = MVENDORID;
            CSR_MARCHID:   readValue = MARCHID;
            CSR_MIMPID:    readValue = MIMPID;
            CSR_MHARTID:   readValue = HART_ID;
            CSR_MISA:      readValue = MISA;
            CSR_MSTATUS:   readValue = mstatusView;
            CSR_MIE:       readValue = mieReg;
            CSR_MTVEC:     readValue = {mtvecBase, 1'b0, mtvecMode};
            CSR_MSCRATCH:  readValue = mscratch;
            CSR_MEPC:      readValue = {mepcHigh, 2'b00};
            CSR_MCAUSE:    readValue = mcause;
            CSR_MTVAL:     readValue = mtval;
            CSR_MIP:       readValue = mipView;
            CSR_MCYCLE:    readValue = mcycle[31:0];
            CSR_MCYCLEH:   readValue = 32'(mcycle[COUNTER_WIDTH-1:32]);
            CSR_MINSTRET:  readValue = minstret[31:0];
            CSR_MINSTRETH: readValue = 32'(minstret[COUNTER_WIDTH-1:32]);
            default:       implemented = 1'b0;
        endcase
    end

    // funct3 000 and 100 both decode to CSR_ACCESS_NONE; 11xx numbers are the read-only space.
    assign accessKind   = csrAccess_t'(i_Op[1:0]);
    assign writeAttempt = (accessKind == CSR_ACCESS_WRITE) || !i_SrcZero;
    assign illegal      = !implemented || (accessKind == CSR_ACCESS_NONE) ||
                          ((i_CsrNumber[11:10] == 2'b11) && writeAttempt);
    assign o_Illegal    = i_Valid && illegal;
    assign doWrite      = i_Valid && !illegal && writeAttempt;
    assign newValue     = applyAccess(accessKind, readValue, i_InputData);
    assign o_ReadData   = readValue;

    assign writeMstatus   = doWrite && (i_CsrNumber == CSR_MSTATUS);
    assign writeMie       = doWrite && (i_CsrNumber == CSR_MIE);
    assign writeMtvec     = doWrite && (i_CsrNumber == CSR_MTVEC);
    assign writeMscratch  = doWrite && (i_CsrNumber == CSR_MSCRATCH);
    assign writeMepc      = doWrite && (i_CsrNumber == CSR_MEPC);
    assign writeMcause    = doWrite && (i_CsrNumber == CSR_MCAUSE);
    assign writeMtval     = doWrite && (i_CsrNumber == CSR_MTVAL);
    assign writeMcycle    = doWrite && (i_CsrNumber == CSR_MCYCLE);
    assign writeMcycleh   = doWrite && (i_CsrNumber == CSR_MCYCLEH);
    assign writeMinstret  = doWrite && (i_CsrNumber == CSR_MINSTRET);
    assign writeMinstreth = doWrite && (i_CsrNumber == CSR_MINSTRETH);

    // NOTE: non-blocking assignments make MPIE<=MIE and MIE<=MPIE read the pre-edge values.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            statusMie  <= 1'b0;
            statusMpie <= 1'b0;
            mtvecBase  <= RESET_MTVEC[31:2];
            mtvecMode  <= 1'b0;
            mieReg     <= '0;
            mscratch   <= '0;
            mepcHigh   <= '0;
            mcause     <= '0;
            mtval      <= '0;
            irqSync    <= '0;
        end else begin
            // Trap beats MRET beats a CSR write on the trap-owned registers.
            if (i_TrapValid) begin
                statusMpie <= statusMie;
                statusMie  <= 1'b0;
            end else if (i_MretValid) begin
                statusMie  <= statusMpie;
                statusMpie <= 1'b1;
            end else if (writeMstatus) begin
                statusMie  <= newValue[MSTATUS_MIE];
                statusMpie <= newValue[MSTATUS_MPIE];
            end

            if (i_TrapValid) begin
                mepcHigh <= i_TrapPc[31:2];
                mcause   <= i_TrapCause;
                mtval    <= i_TrapValue;
            end else begin
                if (writeMepc)   mepcHigh <= newValue[31:2];
                if (writeMcause) mcause   <= newValue;
                if (writeMtval)  mtval    <= newValue;
            end

            if (writeMtvec) begin
                mtvecBase <= newValue[31:2];
                mtvecMode <= VECTORED_EN && newValue[0];
            end
            if (writeMie)      mieReg   <= newValue & MIE_WRITABLE;
            if (writeMscratch) mscratch <= newValue;

            irqSync <= {i_IrqExternal, i_IrqTimer, i_IrqSoftware};
        end
    end

    csr_counter #(.WIDTH(COUNTER_WIDTH)) mcycleCounter (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Increment(1'b1),
        .i_WriteLow (writeMcycle),
        .i_WriteHigh(writeMcycleh),
        .i_WriteData(newValue),
        .o_Value    (mcycle)
    );

    csr_counter #(.WIDTH(COUNTER_WIDTH)) minstretCounter (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Increment(i_InstRetired),
        .i_WriteLow (writeMinstret),
        .i_WriteHigh(writeMinstreth),
        .i_WriteData(newValue),
        .o_Value    (minstret)
    );

    assign pendingEnabled = mipView & mieReg;
    assign o_IrqPending   = statusMie && (|pendingEnabled);

    always_comb begin
        o_IrqCause = '0;
        if (pendingEnabled[MIP_MEIP])      o_IrqCause = CAUSE_M_EXTERNAL;
        else if (pendingEnabled[MIP_MSIP]) o_IrqCause = CAUSE_M_SOFTWARE;
        else if (pendingEnabled[MIP_MTIP]) o_IrqCause = CAUSE_M_TIMER;
    end

    assign o_TrapVector = {mtvecBase, 2'b00} +
                          ((mtvecMode && i_TrapCause[31]) ? {25'b0, i_TrapCause[4:0], 2'b00} : 32'h0);
    assign o_MretPc     = {mepcHigh, 2'b00};

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode control and status register file with trap sequencing, replacing the single-purpose CSR block. It sits beside the execute stage. It serves CSRRW/RS/RC and the immediate forms, owns the mstatus interrupt-enable stack, and latches trap state on exception entry. It also restores that state on MRET, runs the cycle and instret counters, and reports pending interrupts to the control unit.

## Interface
- COUNTER_WIDTH, 64: width of mcycle/minstret, legal range 33..64; the upper bits above 32 are reached through the ...H CSRs.
- HART_ID, 0: constant returned by mhartid.
- RESET_MTVEC, 32'h0000_0000: reset value of mtvec; bits [1:0] must be 0.
- VECTORED_EN, 1: when 0, mtvec.MODE is hardwired to 0 (direct).
- i_Clock  in  1  clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Valid  in  1  CSR instruction executes this cycle.
- i_Op  in  3  funct3 of the instruction.
- i_CsrNumber  in  12  CSR address.
- i_SrcZero  in  1  rs1 index (or uimm) is zero.
- i_InputData  in  32  rs1 value or zero-extended uimm.
- o_ReadData  out  32  old CSR value; combinational.
- o_Illegal  out  1  illegal CSR access; combinational and qualified by i_Valid.
- i_TrapValid  in  1  exception/interrupt is taken this cycle.
- i_TrapCause  in  32  mcause value; bit 31 set means interrupt.
- i_TrapPc  in  32  PC saved into mepc.
- i_TrapValue  in  32  value saved into mtval.
- i_MretValid  in  1  MRET executes this cycle.
- i_InstRetired  in  1  one instruction retires this cycle.
- i_IrqExternal, i_IrqTimer, i_IrqSoftware  in  1 each  interrupt request lines, level-sensitive.
- o_TrapVector  out  32  target PC for the current i_TrapCause.
- o_MretPc  out  32  mepc.
- o_IrqPending  out  1  mstatus.MIE & |(mip & mie).
- o_IrqCause  out  32  cause of the highest-priority pending enabled interrupt.

## Operation
- Implemented registers:
  - mvendorid, marchid, mimpid, mhartid, misa: read-only constants.
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11.
  - mtvec, mie, mscratch, mepc, mcause, mtval.
  - mip: MEIP[11], MTIP[7], MSIP[3], all read-only; each reflects its synchronised IRQ line.
  - mcycle/mcycleh, minstret/minstreth.
- Write-enable rules:
  - RW and RWI always write.
  - RS, RSI, RC and RCI write only when i_SrcZero=0.
  - New value: RW = in, RS = old|in, RC = old&~in.
  - mepc[1:0] always reads 0.
- o_Illegal=1 in any of these cases: unimplemented number; funct3 of 000 or 100; a write to a CSR with number[11:10]=2'b11. When o_Illegal=1, no state changes.
- Trap entry (i_TrapValid):
  - mepc<=i_TrapPc, mcause<=i_TrapCause, mtval<=i_TrapValue.
  - MPIE<=MIE, then MIE<=0.
- MRET: MIE<=MPIE, then MPIE<=1.
- o_TrapVector:
  - Base = {mtvec[31:2],2'b00}.
  - When MODE=1 and i_TrapCause[31]=1, add 4*cause[4:0] to the base.
- Interrupt priority: external(11) > software(3) > timer(7).
- Counters:
  - mcycle increments every cycle.
  - minstret increments when i_InstRetired=1.
  - Both wrap modulo 2^COUNTER_WIDTH.
  - Writing the low half leaves the high half unchanged.
  - The high CSR maps bits [COUNTER_WIDTH-1:32] and reads zero-extended.

## Timing
- Reset clears mstatus, mie, mscratch, mepc, mcause, mtval, the counters and the IRQ synchronisers; mtvec<=RESET_MTVEC.
- Output values in reset: o_IrqPending=0, o_IrqCause=0, o_MretPc=0. o_Illegal=0 whenever i_Valid=0.
- o_ReadData, o_Illegal and o_TrapVector are combinational. All register updates occur on the next posedge of i_Clock.
- IRQ lines pass through one flop into mip. o_IrqPending rises 1 cycle after a line asserts, provided it is enabled.
- Same-cycle priority on mstatus/mepc/mcause/mtval: trap > MRET > CSR write. The losing update is dropped.
- CSR write to a counter in the same cycle as an increment: the written value is stored and the increment is lost.
- Reset asserted mid-operation returns all state to reset values immediately.

## Structure
- Package csr_pkg holds:
  - CSR number constants;
  - funct3 encodings for CSR operations;
  - mstatus/mip bit positions;
  - interrupt cause codes;
  - MVENDORID/MARCHID/MIMPID/MISA constants.
- Sub-module csr_counter (parameter WIDTH) implements the increment, wrap, and low/high half writes. It is instantiated twice, once for mcycle and once for minstret.

## Test plan
- After reset, CSRRS mscratch with i_SrcZero=1 -> o_ReadData=0, o_Illegal=0. Then CSRRW mscratch 32'hDEAD_BEEF -> the next read returns 32'hDEAD_BEEF.
- CSRRW to mvendorid (0xF11) -> o_Illegal=1 and the register is unchanged. CSRRS on 0xF11 with i_SrcZero=1 -> legal, o_Illegal=0.
- Steps:
  1. Set MIE=1, mie.MEIE=1, mtvec=32'h100|1.
  2. Assert i_IrqExternal.
  3. Check o_IrqPending=1 one cycle later and o_IrqCause=32'h8000_000B.
  4. Take the trap with that cause -> o_TrapVector=32'h12C; mstatus reads MPIE=1, MIE=0.
  5. MRET -> MIE=1, MPIE=1.
- Same cycle: i_TrapValid plus CSRRW mepc 32'h40 with i_TrapPc=32'h80 -> mepc=32'h80.
- COUNTER_WIDTH=64:
  1. Write mcycle=32'hFFFF_FFFF and mcycleh=0.
  2. One cycle later, mcycleh reads 1 and mcycle reads 0.
  3. Write mcycleh=32'hFFFF_FFFF and mcycle=32'hFFFF_FFFF; the counter wraps to 0 on the following cycle.
- Assert i_Reset asynchronously mid-trap (between clock edges) -> o_IrqPending drops to 0 without a clock edge, and mepc and mcause read 0.
